spi_frame_sequencer: RTL and testbench

Upstream stage for the SPI `master`. It buffers outgoing MOSI frames in a small FIFO and launches them one at a time by pulsing `PC` and holding `DATA_out`. It waits for the master's completion pulse, then captures the returned MISO frame into a valid/ready response register. It enforces a programmable idle gap between consecutive transactions so the slave sees chip-idle time.

---
 rtl/spi_frame_sequencer.sv | 135 +++++++++++++
 tb/tb_spi_frame_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_sequencer.sv
// Feeds queued MOSI frames to the SPI master one transaction at a time and
// returns each MISO frame through a valid/ready register, with an idle gap between launches.
module spi_frame_sequencer #(
  parameter int frame_length_MOSI = 4,
  parameter int frame_length_MISO = 4,
  parameter int fifo_depth        = 4,
  parameter int gap_cycles        = 2
) (
  input  logic                          clk_in,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [frame_length_MOSI-1:0]  wr_data,
  output logic                          full,
  output logic [$clog2(fifo_depth):0]   count,
  output logic                          PC,
  output logic [frame_length_MOSI-1:0]  DATA_out,
  input  logic                          master_busy,
  input  logic                          master_done,
  input  logic [frame_length_MISO-1:0]  DATA_in,
  output logic                          rd_valid,
  output logic [frame_length_MISO-1:0]  rd_data,
  input  logic                          rd_ready
);

  localparam int ptr_w    = $clog2(fifo_depth);
  localparam int gap_w    = (gap_cycles > 1) ? $clog2(gap_cycles) : 1;
  localparam int gap_load = (gap_cycles > 0) ? gap_cycles - 1 : 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_DELIVER,
    ST_GAP
  } state_t;

  state_t                         state;
  logic [frame_length_MOSI-1:0]   fifo_mem [fifo_depth];
  logic [ptr_w-1:0]               wr_ptr;
  logic [ptr_w-1:0]               rd_ptr;
  logic [frame_length_MISO-1:0]   resp_hold;
  logic [gap_w-1:0]               gap_cnt;
  logic                           push;
  logic                           pop;

  assign full = (count == (ptr_w + 1)'(fifo_depth));
  assign push = wr_en && !full;
  // A frame leaves the FIFO only at the moment the FSM commits to launching it.
  assign pop  = (state == ST_IDLE) && (count != '0) && !master_busy;

  always_ff @(posedge clk_in) begin
    if (push) begin
      fifo_mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The response register is freed by a handshake; a reload in DELIVER overrides the clear.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state     <= ST_IDLE;
      PC        <= 1'b0;
      DATA_out  <= '0;
      resp_hold <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      gap_cnt   <= '0;
    end else begin
      PC <= 1'b0;
      if (rd_valid && rd_ready) begin
        rd_valid <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (pop) begin
            DATA_out <= fifo_mem[rd_ptr];
            PC       <= 1'b1;
            state    <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (master_done) begin
            resp_hold <= DATA_in;
            state     <= ST_DELIVER;
          end
        end
        ST_DELIVER: begin
          if (!rd_valid || rd_ready) begin
            rd_data  <= resp_hold;
            rd_valid <= 1'b1;
            if (gap_cycles == 0) begin
              state <= ST_IDLE;
            end else begin
              gap_cnt <= gap_w'(gap_load);
              state   <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Self-checking bench for spi_frame_sequencer: table of frames with expected
// responses, a behavioural SPI master, and launch/response scoreboards.
module tb_spi_frame_sequencer;

  localparam int DEPTH = 4;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [3:0] wr_data;
  logic       full;
  logic [2:0] count;
  logic       PC;
  logic [3:0] DATA_out;
  logic       master_busy;
  logic       master_done;
  logic [3:0] DATA_in;
  logic       rd_valid;
  logic [3:0] rd_data;
  logic       rd_ready;
  logic       model_busy;
  logic       force_busy;

  typedef struct {
    logic [3:0] data;
    logic [3:0] resp;
    logic       accept;
  } vec_t;

  vec_t       vecs [25];
  logic [3:0] sb_launch [$];
  logic [3:0] sb_resp [$];
  int         pc_log [$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic       prev_pc = 1'b0;

  assign master_busy = model_busy | force_busy;

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  spi_frame_sequencer #(
    .frame_length_MOSI(4),
    .frame_length_MISO(4),
    .fifo_depth(DEPTH),
    .gap_cycles(2)
  ) dut (
    .clk_in(clk_in),
    .rst(rst),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .full(full),
    .count(count),
    .PC(PC),
    .DATA_out(DATA_out),
    .master_busy(master_busy),
    .master_done(master_done),
    .DATA_in(DATA_in),
    .rd_valid(rd_valid),
    .rd_data(rd_data),
    .rd_ready(rd_ready)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int idx);
    wr_en   = 1'b1;
    wr_data = vecs[idx].data;
    @(posedge clk_in);
    #1;
    wr_en = 1'b0;
    if (vecs[idx].accept) begin
      sb_launch.push_back(vecs[idx].data);
      sb_resp.push_back(vecs[idx].resp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic doReset(input int n);
    rst = 1'b1;
    sb_launch.delete();
    sb_resp.delete();
    tick(n);
    rst = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (sb_resp.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    checkOutput("drain_remaining", sb_resp.size(), 0);
    tick(4);
  endtask

  // Behavioural master: done pulse sampled 8 edges after the launch edge, DATA_in = ~frame.
  initial begin
    logic [3:0] d;
    model_busy  = 1'b0;
    master_done = 1'b0;
    DATA_in     = 4'h0;
    forever begin
      @(negedge clk_in);
      if (PC && !rst) begin
        d          = DATA_out;
        model_busy = 1'b1;
        repeat (7) @(posedge clk_in);
        #1;
        master_done = 1'b1;
        DATA_in     = ~d;
        @(posedge clk_in);
        #1;
        master_done = 1'b0;
        model_busy  = 1'b0;
      end
    end
  end

  // Monitor: launch order, response order, single-cycle PC, occupancy bound.
  initial begin
    forever begin
      @(negedge clk_in);
      if (rst) begin
        prev_pc = 1'b0;
      end else begin
        if (PC) begin
          pc_log.push_back(cyc);
          checkOutput("pc_single_cycle", {31'b0, prev_pc}, 0);
          checkOutput("launch_expected", {31'b0, sb_launch.size() > 0}, 1);
          if (sb_launch.size() > 0) begin
            checkOutput("launch_data", DATA_out, sb_launch.pop_front());
          end
        end
        prev_pc = PC;
        checkOutput("count_bound", {31'b0, count <= 3'(DEPTH)}, 1);
        if (rd_valid && rd_ready) begin
          checkOutput("resp_expected", {31'b0, sb_resp.size() > 0}, 1);
          if (sb_resp.size() > 0) begin
            checkOutput("resp_data", rd_data, sb_resp.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    wr_en      = 1'b0;
    wr_data    = 4'h0;
    rd_ready   = 1'b1;
    force_busy = 1'b0;

    vecs[0]  = '{4'hA, 4'h5, 1'b1};
    vecs[1]  = '{4'h1, 4'hE, 1'b1};
    vecs[2]  = '{4'h2, 4'hD, 1'b1};
    vecs[3]  = '{4'h3, 4'hC, 1'b1};
    vecs[4]  = '{4'h4, 4'hB, 1'b1};
    vecs[5]  = '{4'h5, 4'hA, 1'b1};
    vecs[6]  = '{4'h6, 4'h9, 1'b1};
    vecs[7]  = '{4'h7, 4'h8, 1'b1};
    vecs[8]  = '{4'h8, 4'h7, 1'b0};
    vecs[9]  = '{4'hB, 4'h4, 1'b1};
    vecs[10] = '{4'hC, 4'h3, 1'b1};
    vecs[11] = '{4'h5, 4'hA, 1'b1};
    vecs[12] = '{4'hD, 4'h2, 1'b1};
    vecs[13] = '{4'hE, 4'h1, 1'b1};
    vecs[14] = '{4'hF, 4'h0, 1'b1};
    vecs[15] = '{4'h0, 4'hF, 1'b1};
    vecs[16] = '{4'h1, 4'hE, 1'b1};
    vecs[17] = '{4'h2, 4'hD, 1'b1};
    vecs[18] = '{4'h3, 4'hC, 1'b1};
    vecs[19] = '{4'h4, 4'hB, 1'b1};
    vecs[20] = '{4'h5, 4'hA, 1'b1};
    vecs[21] = '{4'h6, 4'h9, 1'b1};
    vecs[22] = '{4'h7, 4'h8, 1'b1};
    vecs[23] = '{4'h8, 4'h7, 1'b1};
    vecs[24] = '{4'h9, 4'h6, 1'b1};

    // Reset state, then push-to-launch latency
    tick(2);
    checkOutput("reset_pc", PC, 0);
    checkOutput("reset_data_out", DATA_out, 0);
    checkOutput("reset_full", full, 0);
    checkOutput("reset_count", count, 0);
    checkOutput("reset_rd_valid", rd_valid, 0);
    checkOutput("reset_rd_data", rd_data, 0);
    rst = 1'b0;
    applyStimulus(0);
    checkOutput("push_count", count, 1);
    checkOutput("pc_before_launch", PC, 0);
    tick(1);
    checkOutput("pc_launch", PC, 1);
    checkOutput("launch_data_out", DATA_out, 4'hA);
    tick(1);
    checkOutput("pc_after_launch", PC, 0);
    checkOutput("data_out_held", DATA_out, 4'hA);
    waitDrain(60);

    // Gap spacing: 8 cycles master + 1 deliver + 2 gap + 1 idle
    pc_log.delete();
    for (int i = 1; i <= 3; i++) applyStimulus(i);
    waitDrain(120);
    checkOutput("gap_pc_count", pc_log.size(), 3);
    if (pc_log.size() == 3) begin
      for (int j = 0; j < 2; j++) begin
        checkOutput("gap_pc_spacing", pc_log[j+1] - pc_log[j], 12);
      end
    end

    // Full FIFO while the master reports busy
    pc_log.delete();
    force_busy = 1'b1;
    for (int i = 4; i <= 8; i++) begin
      applyStimulus(i);
      if (i == 7) begin
        checkOutput("full_after_4th", full, 1);
        checkOutput("count_after_4th", count, 4);
      end
    end
    checkOutput("count_after_drop", count, 4);
    checkOutput("full_after_drop", full, 1);
    tick(3);
    checkOutput("busy_blocks_launch", pc_log.size(), 0);
    force_busy = 1'b0;
    waitDrain(150);
    checkOutput("full_launches", pc_log.size(), 4);

    // Backpressure holds the second response in DELIVER
    pc_log.delete();
    rd_ready = 1'b0;
    for (int i = 9; i <= 11; i++) applyStimulus(i);
    tick(50);
    checkOutput("bp_pc_count", pc_log.size(), 2);
    checkOutput("bp_rd_valid", rd_valid, 1);
    checkOutput("bp_rd_data_first", rd_data, 4'h4);
    checkOutput("bp_count", count, 1);
    rd_ready = 1'b1;
    tick(1);
    rd_ready = 1'b0;
    checkOutput("bp_rd_data_second", rd_data, 4'h3);
    checkOutput("bp_rd_valid_kept", rd_valid, 1);
    tick(3);
    checkOutput("bp_no_third_pc", pc_log.size(), 2);
    rd_ready = 1'b1;
    waitDrain(100);
    checkOutput("bp_total_pc", pc_log.size(), 3);

    // Reset while waiting on the master with two frames queued
    for (int i = 12; i <= 14; i++) applyStimulus(i);
    checkOutput("mid_count_before", count, 2);
    tick(2);
    doReset(2);
    pc_log.delete();
    checkOutput("mid_count", count, 0);
    checkOutput("mid_full", full, 0);
    checkOutput("mid_pc", PC, 0);
    checkOutput("mid_data_out", DATA_out, 0);
    checkOutput("mid_rd_valid", rd_valid, 0);
    for (int k = 0; k < 20; k++) begin
      tick(1);
      checkOutput("late_done_ignored", rd_valid, 0);
    end
    checkOutput("mid_no_pc", pc_log.size(), 0);

    // Wrap-around with pushes overlapping launches
    pc_log.delete();
    for (int i = 15; i <= 24; i++) begin
      int n = 0;
      while (full && n < 100) begin
        tick(1);
        n++;
      end
      checkOutput("wrap_space_available", full, 0);
      applyStimulus(i);
    end
    waitDrain(400);
    checkOutput("wrap_pc_count", pc_log.size(), 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
